// File: rtl/sc_points_scheduler.sv
// Game-flow controller for the points counter.
// Sequences IDLE / PLAY / CRASH / LEVELUP / LOSE / WIN from road ticks,
// crash events and the start button. It produces the level-progress,
// current-level, player-lose and up-count strobes that the counter consumes.
// All outputs come straight from flops; State_Out exposes the FSM state.
//
// Handshake/strobe semantics: road_tick_in is a one-cycle high pulse and is
// counted once per cycle it is high. upCount_outLow is a one-cycle low pulse
// meaning "award exactly one point", with no back-pressure from the counter.
module sc_points_scheduler #(
    parameter int POINT_DIV      = 4,
    parameter int PROGRESS_MAX   = 31,
    parameter int LEVEL_MAX      = 5,
    parameter int LIVES_INIT     = 3,
    parameter int CRASH_CYCLES   = 16,
    parameter int LEVELUP_CYCLES = 8
) (
    input  logic       SC_POINTSCOUNTER_CLOCK_50,
    input  logic       SC_POINTSCOUNTER_RESET_InHigh,
    input  logic       start_inLow,
    input  logic       crash_inLow,
    input  logic       road_tick_in,
    output logic [4:0] LevelProgress_Out,
    output logic [2:0] CurrentLvl_Out,
    output logic       PlayerLose_outLow,
    output logic       upCount_outLow,
    output logic [2:0] Lives_Out,
    output logic [2:0] State_Out
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_CRASH   = 3'd2,
        ST_LEVELUP = 3'd3,
        ST_LOSE    = 3'd4,
        ST_WIN     = 3'd5
    } state_t;

    localparam logic [4:0] PROG_LAST  = 5'(PROGRESS_MAX);
    // Points only start accruing once progress has reached this value.
    localparam logic [4:0] PROG_SCORE = 5'd8;
    localparam logic [3:0] DIV_LAST   = 4'(POINT_DIV - 1);
    localparam logic [2:0] LVL_LAST   = 3'(LEVEL_MAX);
    localparam logic [2:0] LIVES_LOAD = 3'(LIVES_INIT);
    localparam logic [7:0] CRASH_LOAD = 8'(CRASH_CYCLES);
    localparam logic [7:0] LVLUP_LOAD = 8'(LEVELUP_CYCLES);

    state_t     state_q,      state_d;
    logic [4:0] progress_q,   progress_d;
    logic [2:0] level_q,      level_d;
    logic [2:0] lives_q,      lives_d;
    logic [3:0] div_q,        div_d;
    logic [7:0] delay_q,      delay_d;
    logic       upcount_q,    upcount_d;
    logic       lose_q,       lose_d;
    logic       start_prev_q, start_prev_d;

    logic start_evt;

    // Next-state and next-output computation for the whole game flow.
    always_comb begin
        state_d      = state_q;
        progress_d   = progress_q;
        level_d      = level_q;
        lives_d      = lives_q;
        div_d        = div_q;
        delay_d      = delay_q;
        upcount_d    = 1'b1;
        start_prev_d = start_inLow;

        // A press is the 1->0 transition, so holding the button fires once.
        start_evt = start_prev_q & ~start_inLow;

        case (state_q)
            ST_IDLE: begin
                if (start_evt) begin
                    state_d    = ST_PLAY;
                    level_d    = 3'd1;
                    lives_d    = LIVES_LOAD;
                    progress_d = 5'd0;
                    div_d      = 4'd0;
                end
            end

            ST_PLAY: begin
                // Crash wins over a tick arriving in the same cycle.
                if (!crash_inLow) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        delay_d = CRASH_LOAD;
                        state_d = ST_CRASH;
                    end else begin
                        lives_d = 3'd0;
                        state_d = ST_LOSE;
                    end
                end else if (road_tick_in) begin
                    if (progress_q != PROG_LAST) begin
                        progress_d = progress_q + 5'd1;
                    end
                    // The divider runs on the pre-increment progress value.
                    if (progress_q >= PROG_SCORE) begin
                        if (div_q == DIV_LAST) begin
                            div_d     = 4'd0;
                            upcount_d = 1'b0;
                        end else begin
                            div_d = div_q + 4'd1;
                        end
                    end
                    if (progress_d == PROG_LAST) begin
                        delay_d = LVLUP_LOAD;
                        state_d = ST_LEVELUP;
                    end
                end
            end

            ST_CRASH: begin
                delay_d = delay_q - 8'd1;
                if (delay_q == 8'd1) begin
                    state_d = ST_PLAY;
                end
            end

            ST_LEVELUP: begin
                progress_d = PROG_LAST;
                delay_d    = delay_q - 8'd1;
                if (delay_q == 8'd1) begin
                    if (level_q == LVL_LAST) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d    = level_q + 3'd1;
                        progress_d = 5'd0;
                        div_d      = 4'd0;
                        state_d    = ST_PLAY;
                    end
                end
            end

            ST_LOSE, ST_WIN: begin
                if (start_evt) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered so the lose flag lines up with State_Out showing LOSE.
        lose_d = (state_d != ST_LOSE);
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge SC_POINTSCOUNTER_CLOCK_50 or posedge SC_POINTSCOUNTER_RESET_InHigh) begin
        if (SC_POINTSCOUNTER_RESET_InHigh) begin
            state_q      <= ST_IDLE;
            progress_q   <= 5'd0;
            level_q      <= 3'd0;
            lives_q      <= 3'd0;
            div_q        <= 4'd0;
            delay_q      <= 8'd0;
            upcount_q    <= 1'b1;
            lose_q       <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            progress_q   <= progress_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            div_q        <= div_d;
            delay_q      <= delay_d;
            upcount_q    <= upcount_d;
            lose_q       <= lose_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign LevelProgress_Out = progress_q;
    assign CurrentLvl_Out    = level_q;
    assign Lives_Out         = lives_q;
    assign upCount_outLow    = upcount_q;
    assign PlayerLose_outLow = lose_q;
    assign State_Out         = state_q;

endmodule

// File: tb/tb_sc_points_scheduler.sv
// Scoreboard bench for sc_points_scheduler with default parameters.
// The driver pushes expected observations (state changes, point pulses,
// requested snapshots) into exp_q; a monitor pops and compares whenever the
// DUT presents one of those observations.
module tb_sc_points_scheduler;

    logic       clk;
    logic       rst;
    logic       start_inLow;
    logic       crash_inLow;
    logic       road_tick_in;
    logic [4:0] LevelProgress_Out;
    logic [2:0] CurrentLvl_Out;
    logic       PlayerLose_outLow;
    logic       upCount_outLow;
    logic [2:0] Lives_Out;
    logic [2:0] State_Out;

    sc_points_scheduler dut (
        .SC_POINTSCOUNTER_CLOCK_50     (clk),
        .SC_POINTSCOUNTER_RESET_InHigh (rst),
        .start_inLow                   (start_inLow),
        .crash_inLow                   (crash_inLow),
        .road_tick_in                  (road_tick_in),
        .LevelProgress_Out             (LevelProgress_Out),
        .CurrentLvl_Out                (CurrentLvl_Out),
        .PlayerLose_outLow             (PlayerLose_outLow),
        .upCount_outLow                (upCount_outLow),
        .Lives_Out                     (Lives_Out),
        .State_Out                     (State_Out)
    );

    // Record layout: kind[24:23] state[22:20] level[19:17] lives[16:14]
    //                progress[13:9] lose[8] dwell[7:0]
    localparam int K_CHG   = 0;
    localparam int K_PULSE = 1;
    localparam int K_SNAP  = 2;

    localparam logic [24:0] MSK_ALL  = '1;
    // Level/lives/progress are not compared when leaving LOSE/WIN for IDLE.
    localparam logic [24:0] MSK_HOLD = MSK_ALL ^ {5'b0, 3'b111, 3'b111, 5'b11111, 1'b0, 8'b0};

    logic [24:0] exp_q[$];
    logic [24:0] msk_q[$];
    int checks = 0;
    int errors = 0;
    int snap_cnt = 0;
    int snap_seen = 0;

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [24:0] mk(input int k, input int st, input int lv,
                                       input int li, input int pr, input int lo,
                                       input int dw);
        return {2'(k), 3'(st), 3'(lv), 3'(li), 5'(pr), 1'(lo), 8'(dw)};
    endfunction

    function automatic string kname(input logic [1:0] k);
        case (k)
            2'd0:    return "state_change";
            2'd1:    return "point_pulse";
            default: return "snapshot";
        endcase
    endfunction

    task automatic push(input int k, input int st, input int lv, input int li,
                        input int pr, input int lo, input int dw,
                        input logic [24:0] m);
        exp_q.push_back(mk(k, st, lv, li, pr, lo, dw));
        msk_q.push_back(m);
    endtask

    task automatic sb_check(input logic [24:0] got);
        logic [24:0] e;
        logic [24:0] m;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_%s: got=%h required=none", kname(got[24:23]), got);
        end else begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            if ((got & m) != (e & m)) begin
                errors++;
                $display("FAIL sb_%s: got=%h required=%h mask=%h", kname(e[24:23]), got, e, m);
            end
        end
    endtask

    task automatic direct_check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic raw_tick();
        @(negedge clk) road_tick_in = 1'b1;
        @(negedge clk) road_tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic raw_crash(input logic with_tick);
        @(negedge clk);
        crash_inLow  = 1'b0;
        road_tick_in = with_tick;
        @(negedge clk);
        crash_inLow  = 1'b1;
        road_tick_in = 1'b0;
    endtask

    task automatic start_press(input int hold);
        @(negedge clk) start_inLow = 1'b0;
        repeat (hold) @(negedge clk);
        start_inLow = 1'b1;
        @(negedge clk);
    endtask

    task automatic snap(input int st, input int lv, input int li, input int pr, input int lo);
        push(K_SNAP, st, lv, li, pr, lo, 0, MSK_ALL);
        @(negedge clk) snap_cnt++;
        repeat (2) @(negedge clk);
    endtask

    // Ticks taking progress from 'from' to 'to'; with the default POINT_DIV=4
    // and a divider that starts counting at progress 8, a fresh level pays a
    // point on reaching 12, 16, 20, 24 and 28; reaching 31 enters LEVELUP.
    task automatic tick_range(input int lv, input int li, input int from, input int to);
        for (int p = from; p <= to; p++) begin
            if (p == 31) push(K_CHG, 3, lv, li, 31, 1, 0, MSK_ALL);
            if (p >= 12 && p % 4 == 0) push(K_PULSE, 1, lv, li, p, 1, 0, MSK_ALL);
            raw_tick();
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge
    initial begin
        logic [2:0] prev;
        int dwell;
        logic [7:0] dw;
        wait (rst == 1'b0);
        prev  = State_Out;
        dwell = 0;
        forever begin
            @(posedge clk);
            #1;
            if (State_Out != prev) begin
                // Dwell is reported only for timed freezes that run out.
                dw = ((prev == 3'd2 || prev == 3'd3) && (State_Out == 3'd1 || State_Out == 3'd5))
                     ? dwell[7:0] : 8'd0;
                sb_check({2'(K_CHG), State_Out, CurrentLvl_Out, Lives_Out,
                          LevelProgress_Out, PlayerLose_outLow, dw});
                prev  = State_Out;
                dwell = 1;
            end else begin
                dwell++;
            end
            if (!upCount_outLow) begin
                sb_check({2'(K_PULSE), State_Out, CurrentLvl_Out, Lives_Out,
                          LevelProgress_Out, PlayerLose_outLow, 8'd0});
            end
            if (snap_cnt != snap_seen) begin
                snap_seen++;
                sb_check({2'(K_SNAP), State_Out, CurrentLvl_Out, Lives_Out,
                          LevelProgress_Out, PlayerLose_outLow, 8'd0});
            end
        end
    end

    // Directed stimulus
    initial begin
        rst          = 1'b1;
        start_inLow  = 1'b1;
        crash_inLow  = 1'b1;
        road_tick_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        snap(0, 0, 0, 0, 1);

        // Start held for 10 cycles: exactly one transition into PLAY
        push(K_CHG, 1, 1, 3, 0, 1, 0, MSK_ALL);
        start_press(10);
        snap(1, 1, 3, 0, 1);

        // Point rate: 16 ticks, pulses after ticks 12 and 16
        tick_range(1, 3, 1, 16);
        snap(1, 1, 3, 16, 1);

        // Crash with a simultaneous tick; ticks and a crash during the freeze
        push(K_CHG, 2, 1, 2, 16, 1, 0, MSK_ALL);
        raw_crash(1'b1);
        raw_tick();
        raw_tick();
        raw_crash(1'b0);
        snap(2, 1, 2, 16, 1);
        push(K_CHG, 1, 1, 2, 16, 1, 16, MSK_ALL);
        repeat (8) @(negedge clk);
        snap(1, 1, 2, 16, 1);

        // Finish level 1, then levels 2..5, ending in WIN
        tick_range(1, 2, 17, 31);
        push(K_CHG, 1, 2, 2, 0, 1, 8, MSK_ALL);
        repeat (10) @(negedge clk);
        for (int lv = 2; lv <= 5; lv++) begin
            tick_range(lv, 2, 1, 31);
            if (lv < 5) push(K_CHG, 1, lv + 1, 2, 0, 1, 8, MSK_ALL);
            else        push(K_CHG, 5, 5, 2, 31, 1, 8, MSK_ALL);
            repeat (10) @(negedge clk);
        end
        snap(5, 5, 2, 31, 1);

        // WIN -> IDLE -> PLAY
        push(K_CHG, 0, 0, 0, 0, 1, 0, MSK_HOLD);
        start_press(3);
        push(K_CHG, 1, 1, 3, 0, 1, 0, MSK_ALL);
        start_press(3);

        // Three crashes -> LOSE
        push(K_CHG, 2, 1, 2, 0, 1, 0, MSK_ALL);
        raw_crash(1'b0);
        push(K_CHG, 1, 1, 2, 0, 1, 16, MSK_ALL);
        repeat (20) @(negedge clk);
        push(K_CHG, 2, 1, 1, 0, 1, 0, MSK_ALL);
        raw_crash(1'b0);
        push(K_CHG, 1, 1, 1, 0, 1, 16, MSK_ALL);
        repeat (20) @(negedge clk);
        push(K_CHG, 4, 1, 0, 0, 0, 0, MSK_ALL);
        raw_crash(1'b0);
        repeat (3) @(negedge clk);
        snap(4, 1, 0, 0, 0);

        // Restart from LOSE
        push(K_CHG, 0, 0, 0, 0, 1, 0, MSK_HOLD);
        start_press(3);
        push(K_CHG, 1, 1, 3, 0, 1, 0, MSK_ALL);
        start_press(3);

        // A start press during PLAY changes nothing
        start_press(3);
        snap(1, 1, 3, 0, 1);

        // Async reset in the middle of LEVELUP
        tick_range(1, 3, 1, 31);
        repeat (2) @(negedge clk);
        push(K_CHG, 0, 0, 0, 0, 1, 0, MSK_ALL);
        #2 rst = 1'b1;
        #1;
        direct_check("rst_state",    int'(State_Out),         0);
        direct_check("rst_level",    int'(CurrentLvl_Out),    0);
        direct_check("rst_lives",    int'(Lives_Out),         0);
        direct_check("rst_progress", int'(LevelProgress_Out), 0);
        direct_check("rst_lose",     int'(PlayerLose_outLow), 1);
        direct_check("rst_upcount",  int'(upCount_outLow),    1);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(negedge clk);
        snap(0, 0, 0, 0, 1);
        push(K_CHG, 1, 1, 3, 0, 1, 0, MSK_ALL);
        start_press(3);
        snap(1, 1, 3, 0, 1);

        // Every expected observation must have been seen
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got=%0d outstanding required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
